div_const_pipe: RTL and testbench

- Pipelined unsigned divider by a compile-time constant; returns quotient and remainder.
- Successor to the flat 36-bit ÷113 LUT network: generalised in WIDTH, DIVISOR and digit size CHUNK.
- Adds a pipeline register per digit, valid/ready flow control with backpressure, and a sideband tag.
- Sits in the datapath wherever fixed-constant division is needed at line rate: one result per cycle, fixed latency.

---
 rtl/div_const_pkg.sv | 29 ++
 rtl/div_const_digit.sv | 39 +++
 rtl/div_const_pipe.sv | 120 ++++++++++++
 tb/tb_div_const_pipe.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_const_pkg.sv
// ============================================================================
// Module   : div_const_pkg
// Purpose  : Shared sizing helpers and legal parameter limits for div_const_pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

package div_const_pkg;

    localparam int c_MAX_DIVISOR = 1 << 20;
    localparam int c_MAX_CHUNK   = 16;

    // Smallest n with 2**n >= value; sizes the partial remainder.
    function automatic int clog2(input int value);
        int n;
        n = 0;
        while ((longint'(1) << n) < longint'(value)) begin
            n++;
        end
        return n;
    endfunction

    function automatic int nstages(input int width, input int chunk);
        return (width + chunk - 1) / chunk;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_const_digit.sv
// ============================================================================
// Module   : div_const_digit
// Purpose  : One radix-2^CHUNK digit of constant division (restoring compare-subtract).
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_const_digit #(
    parameter int DIVISOR = 113,
    parameter int CHUNK   = 7,
    parameter int RW      = 7
) (
    input  logic [RW-1:0]    r_in_i,
    input  logic [CHUNK-1:0] chunk_i,
    output logic [CHUNK-1:0] q_digit_o,
    output logic [RW-1:0]    r_out_o
);

    localparam int c_TW = RW + CHUNK;
    localparam logic [c_TW-1:0] c_DIV = c_TW'(DIVISOR);

    logic [c_TW-1:0] w_t;

    // r_in < DIVISOR keeps every DIVISOR<<j inside c_TW bits and the digit below 2^CHUNK.
    always_comb begin
        w_t       = {r_in_i, chunk_i};
        q_digit_o = '0;
        for (int j = CHUNK - 1; j >= 0; j--) begin
            if (w_t >= (c_DIV << j)) begin
                w_t          = w_t - (c_DIV << j);
                q_digit_o[j] = 1'b1;
            end
        end
        r_out_o = w_t[RW-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/div_const_pipe.sv
// ============================================================================
// Module   : div_const_pipe
// Purpose  : Pipelined unsigned divide-by-constant, one digit per stage, valid/ready.
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_const_pipe
    import div_const_pkg::*;
#(
    parameter int WIDTH   = 36,
    parameter int DIVISOR = 113,
    parameter int CHUNK   = 7,
    parameter int TAGW    = 4,
    localparam int RW     = clog2(DIVISOR)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_q,
    output logic [RW-1:0]    out_r,
    output logic [TAGW-1:0]  out_tag
);

    localparam int c_NST = nstages(WIDTH, CHUNK);
    localparam int c_PW  = c_NST * CHUNK;

    if (DIVISOR < 2 || DIVISOR > c_MAX_DIVISOR || CHUNK < 1 || CHUNK > c_MAX_CHUNK) begin : g_bad_param
        $error("div_const_pipe: DIVISOR must be 2..2^20 and CHUNK 1..16");
    end

    typedef logic [c_PW-1:0]  pw_t;
    typedef logic [WIDTH-1:0] q_t;

    typedef struct packed {
        logic            valid;
        logic [RW-1:0]   rem;
        logic [WIDTH-1:0] qacc;
        logic [TAGW-1:0] tag;
    } stage_t;

    stage_t r_stage_q [c_NST];
    logic   w_adv;

    assign w_adv     = ~r_stage_q[c_NST-1].valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_stage_q[c_NST-1].valid;
    assign out_q     = r_stage_q[c_NST-1].qacc;
    assign out_r     = r_stage_q[c_NST-1].rem;
    assign out_tag   = r_stage_q[c_NST-1].tag;

    for (genvar k = 0; k < c_NST; k++) begin : g_stage
        // Unconsumed dividend bits shrink by one chunk per stage.
        localparam int c_XW = (c_NST - k) * CHUNK;

        stage_t           w_prev;
        logic [c_XW-1:0]  w_xin;
        logic [CHUNK-1:0] w_qdig;
        logic [RW-1:0]    w_rout;
        logic [WIDTH-1:0] w_qacc_d;

        if (k == 0) begin : g_head
            assign w_prev.valid = in_valid;
            assign w_prev.rem   = '0;
            assign w_prev.qacc  = '0;
            assign w_prev.tag   = in_tag;
            assign w_xin        = pw_t'(in_x);
        end else begin : g_body
            assign w_prev = r_stage_q[k-1];
            assign w_xin  = g_stage[k-1].g_rest.r_xrest_q;
        end

        div_const_digit #(
            .DIVISOR (DIVISOR),
            .CHUNK   (CHUNK),
            .RW      (RW)
        ) u_digit (
            .r_in_i    (w_prev.rem),
            .chunk_i   (w_xin[c_XW-1 -: CHUNK]),
            .q_digit_o (w_qdig),
            .r_out_o   (w_rout)
        );

        // Padding digits are zero, so truncating to WIDTH loses nothing.
        assign w_qacc_d = q_t'((pw_t'(w_prev.qacc) << CHUNK) | pw_t'(w_qdig));

        always_ff @(posedge clk) begin
            if (rst) begin
                r_stage_q[k] <= '0;
            end else if (w_adv) begin
                r_stage_q[k].valid <= w_prev.valid;
                if (w_prev.valid) begin
                    r_stage_q[k].rem  <= w_rout;
                    r_stage_q[k].qacc <= w_qacc_d;
                    r_stage_q[k].tag  <= w_prev.tag;
                end
            end
        end

        if (k < c_NST - 1) begin : g_rest
            logic [c_XW-CHUNK-1:0] r_xrest_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_xrest_q <= '0;
                end else if (w_adv && w_prev.valid) begin
                    r_xrest_q <= w_xin[c_XW-CHUNK-1:0];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_div_const_pipe.sv
// ============================================================================
// Module   : tb_div_const_pipe
// Purpose  : Self-checking bench for div_const_pipe with a floor/mod scoreboard.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_div_const_pipe;

    localparam int c_W   = 36;
    localparam int c_D   = 113;
    localparam int c_C   = 7;
    localparam int c_NST = (c_W + c_C - 1) / c_C;

    typedef struct {
        longint x;
        longint q;
        longint r;
        int     tag;
        longint acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic            in_valid, in_ready, out_valid, out_ready;
    logic [35:0]     in_x, out_q;
    logic [3:0]      in_tag, out_tag;
    logic [6:0]      out_r;

    logic            sw_valid, sw_ordy;
    logic [35:0]     sw_x;
    logic [3:0]      sw_tag;
    logic            a_irdy, a_ov, b_irdy, b_ov, c_irdy, c_ov;
    logic [15:0]     a_q;
    logic [1:0]      a_r;
    logic [19:0]     b_q;
    logic [9:0]      b_r;
    logic [7:0]      c_q, c_r;
    logic [3:0]      a_tag, b_tag, c_tag;

    exp_t   mq[$];
    exp_t   sq[3][$];
    exp_t   m_new;
    int     n_chk = 0;
    int     n_pass = 0;
    int     n_acc = 0;
    bit     lat_en = 1'b0;
    longint cyc = 0;

    assign sw_ordy = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_const_pipe u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_q(out_q), .out_r(out_r), .out_tag(out_tag)
    );

    div_const_pipe #(.WIDTH(16), .DIVISOR(3), .CHUNK(4), .TAGW(4)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(sw_valid), .in_ready(a_irdy), .in_x(sw_x[15:0]), .in_tag(sw_tag),
        .out_valid(a_ov), .out_ready(sw_ordy), .out_q(a_q), .out_r(a_r), .out_tag(a_tag)
    );

    div_const_pipe #(.WIDTH(20), .DIVISOR(1000), .CHUNK(6), .TAGW(4)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(sw_valid), .in_ready(b_irdy), .in_x(sw_x[19:0]), .in_tag(sw_tag),
        .out_valid(b_ov), .out_ready(sw_ordy), .out_q(b_q), .out_r(b_r), .out_tag(b_tag)
    );

    div_const_pipe #(.WIDTH(8), .DIVISOR(255), .CHUNK(8), .TAGW(4)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(sw_valid), .in_ready(c_irdy), .in_x(sw_x[7:0]), .in_tag(sw_tag),
        .out_valid(c_ov), .out_ready(sw_ordy), .out_q(c_q), .out_r(c_r), .out_tag(c_tag)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Main DUT scoreboard: outputs must match the queue head on every valid cycle.
    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            check("in_ready_rule", longint'(in_ready), longint'(!out_valid || out_ready));
            if (out_valid) begin
                if (mq.size() == 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    check("q", longint'(out_q), mq[0].q);
                    check("r", longint'(out_r), mq[0].r);
                    check("tag", longint'(out_tag), longint'(mq[0].tag));
                    if (out_ready) begin
                        if (lat_en) check("latency", cyc - mq[0].acc, c_NST);
                        void'(mq.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                m_new.x   = longint'(in_x);
                m_new.q   = m_new.x / c_D;
                m_new.r   = m_new.x % c_D;
                m_new.tag = int'(in_tag);
                m_new.acc = cyc;
                mq.push_back(m_new);
                n_acc++;
            end
        end
    end

    task automatic sw_step(input int id, input longint d, input int w, input logic ir,
                           input logic ov, input longint q, input longint r, input int tg);
        exp_t   e;
        longint xm;
        check($sformatf("sw%0d_in_ready", id), longint'(ir), 1);
        if (ov) begin
            if (sq[id].size() == 0) begin
                check($sformatf("sw%0d_spurious", id), 1, 0);
            end else begin
                check($sformatf("sw%0d_q", id), q, sq[id][0].q);
                check($sformatf("sw%0d_r", id), r, sq[id][0].r);
                check($sformatf("sw%0d_tag", id), longint'(tg), longint'(sq[id][0].tag));
                void'(sq[id].pop_front());
            end
        end
        if (sw_valid) begin
            xm    = longint'(sw_x) & ((longint'(1) << w) - 1);
            e.x   = xm;
            e.q   = xm / d;
            e.r   = xm % d;
            e.tag = int'(sw_tag);
            e.acc = cyc;
            sq[id].push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) sq[i].delete();
        end else begin
            sw_step(0, 3,    16, a_irdy, a_ov, longint'(a_q), longint'(a_r), int'(a_tag));
            sw_step(1, 1000, 20, b_irdy, b_ov, longint'(b_q), longint'(b_r), int'(b_tag));
            sw_step(2, 255,  8,  c_irdy, c_ov, longint'(c_q), longint'(c_r), int'(c_tag));
        end
    end

    task automatic drive(input logic v, input logic [35:0] x, input logic [3:0] t, input logic ordy);
        in_valid  = v;
        in_x      = x;
        in_tag    = t;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1);
    end

    initial begin
        logic [35:0] dir_x [5];
        int          base;
        bit          hold;

        in_valid = 0; in_x = '0; in_tag = '0; out_ready = 1'b1;
        sw_valid = 0; sw_x = '0; sw_tag = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_q", longint'(out_q), 0);
        check("rst_out_r", longint'(out_r), 0);
        check("rst_out_tag", longint'(out_tag), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", longint'(in_ready), 1);

        // Directed back-to-back operands with a fixed-latency expectation.
        dir_x[0] = 36'd0;
        dir_x[1] = 36'd112;
        dir_x[2] = 36'd113;
        dir_x[3] = 36'd12769;
        dir_x[4] = 36'hF_FFFF_FFFF;
        lat_en = 1'b1;
        for (int i = 0; i < 5; i++) drive(1'b1, dir_x[i], 4'(i), 1'b1);
        repeat (10) drive(1'b0, '0, '0, 1'b1);
        lat_en = 1'b0;
        check("directed_drained", longint'(mq.size()), 0);

        // Backpressure: stall the consumer for 5 cycles while the stream continues.
        base = n_acc;
        for (int c = 0; c < 40; c++) begin
            hold      = (c >= 7 && c < 12);
            in_valid  = (n_acc - base) < 10;
            in_x      = {4'($urandom), $urandom};
            in_tag    = 4'(c);
            out_ready = !hold;
            #1;
            if (hold) begin
                check("hold_out_valid", longint'(out_valid), 1);
                check("hold_in_ready", longint'(in_ready), 0);
            end
            @(posedge clk);
            #1;
        end
        check("bp_accepts", longint'(n_acc - base), 10);
        check("bp_drained", longint'(mq.size()), 0);

        // Reset with four operands in flight.
        for (int i = 0; i < 4; i++) drive(1'b1, {4'($urandom), $urandom}, 4'(8 + i), 1'b1);
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("midrst_out_valid", longint'(out_valid), 0);
            check("midrst_out_tag", longint'(out_tag), 0);
            drive(1'b0, '0, '0, 1'b1);
        end

        // Random valid/ready traffic.
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom), {4'($urandom), $urandom}, 4'($urandom), 1'($urandom));
        end
        for (int i = 0; i < 50 && mq.size() != 0; i++) drive(1'b0, '0, '0, 1'b1);
        check("random_drained", longint'(mq.size()), 0);

        // Parameter sweep instances: all-ones boundary, zero, then random.
        for (int i = 0; i < 1002; i++) begin
            sw_valid = 1'b1;
            if (i == 0)      sw_x = 36'hF_FFFF_FFFF;
            else if (i == 1) sw_x = 36'd0;
            else             sw_x = {4'($urandom), $urandom};
            sw_tag = 4'(i);
            @(posedge clk);
            #1;
        end
        sw_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) check($sformatf("sw%0d_drained", i), longint'(sq[i].size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
